sisc_fetch: RTL and testbench
=============================

Name: sisc_fetch

Overview:
- Instruction fetch unit for the SISC processor.
- Owns the program counter and reads 32-bit instruction words from instruction memory over a req/ack interface.
- Holds each fetched word in the instruction register and delivers it to the SISC datapath/ctrl (`ir` input of the core) over a valid/ready handshake.
- Handles branch redirects from ctrl, including flushing in-flight or undelivered fetches, and stops cleanly on halt.

Parameters:
- ADDR_W, 16, width of the program counter and instruction memory word address.
- RST_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- imem_req  output  1  instruction memory read request.
- imem_addr  output  ADDR_W  word address of the request.
- imem_ack  input  1  memory has returned data this cycle.
- imem_rdata  input  32  instruction word; valid when imem_ack=1.
- ir  output  32  instruction register to the SISC core.
- ir_valid  output  1  ir holds an undelivered instruction.
- ir_ready  input  1  core accepts ir this cycle.
- br_taken  input  1  redirect request from ctrl.
- br_addr  input  ADDR_W  branch target word address.
- halt  input  1  core requests stop after the current delivery.
- pc  output  ADDR_W  current program counter: address of the next fetch.
- halted  output  1  fetch unit stopped.

Behaviour:
- Reset: one clk edge with rst=1. Post-reset values:
  - state=REQ, pc=RST_PC, ir=0, ir_valid=0, halted=0, flush=0.
  - imem_req is registered low during the reset cycle and rises on the first cycle after rst deasserts.
  - rst asserted in any state overrides all other inputs, including an outstanding request. The memory must tolerate an abandoned request.
- States: REQ, ISSUE, HALTED.
- REQ:
  - Drive imem_req=1 and imem_addr=pc.
  - imem_addr stays stable until imem_ack. There is no withdrawal of a request once raised.
  - On imem_ack with flush=0:
    - ir<=imem_rdata, ir_valid<=1.
    - pc<=pc+1, modulo 2^ADDR_W (all-ones wraps to 0).
    - Go to ISSUE.
  - On imem_ack with flush=1: discard data, flush<=0, stay in REQ. The next request uses the updated pc.
  - br_taken in REQ without ack: pc is not changed (address held), flush<=1, and the target is latched into pending_pc. On the discard ack, pc<=pending_pc.
  - br_taken in REQ on the same cycle as ack: discard data, pc<=br_addr, stay in REQ.
- ISSUE:
  - imem_req=0; ir and ir_valid are held stable while ir_ready=0.
  - ir_ready=1: delivery complete. ir_valid<=0 next cycle; ir keeps its last value.
    - If halt=1, go to HALTED.
    - Else go to REQ.
    - br_taken in the same cycle means the branch instruction itself is being accepted: pc<=br_addr, then go to REQ.
  - br_taken with ir_ready=0: flush the undelivered word. ir_valid<=0, pc<=br_addr, go to REQ.
  - halt is ignored unless ir_ready=1 in ISSUE.
- HALTED:
  - imem_req=0, ir_valid=0, halted=1.
  - br_taken and halt are ignored. Only rst leaves this state.
- br_taken and halt together at a handshake: pc<=br_addr, then HALTED. pc is observable for restart/debug.
- Latency with zero-wait memory (ack in the same cycle as req): 2 cycles per instruction, i.e. REQ then ISSUE. With N wait cycles: N+2.
- Only one request is ever outstanding. ir never changes while ir_valid=1.

Test Plan:
- Sequential fetch, zero-wait memory returning data=addr*3, ir_ready tied 1, RST_PC=0:
  - ir sequence 0,3,6,9.
  - ir_valid pulses every 2nd cycle.
  - pc reads 4 after the 4th delivery.
- Wait states:
  - ack delayed 3 cycles → imem_req/imem_addr held constant for 4 cycles; the instruction is delivered one cycle later.
  - ir_ready=0 for 5 cycles → ir and ir_valid stable throughout.
- Branch at handshake: deliver word at pc=5 with br_taken=1, br_addr=0x0040 → next imem_addr=0x0040; no fetch at address 6.
- Branch during outstanding request: br_taken while waiting on address 7 → address 7 held until ack, data discarded (no ir_valid), next request to br_addr.
- Wrap and halt:
  - RST_PC=0xFFFF → after the first delivery pc=0x0000.
  - halt with ir_ready → halted=1, imem_req stays 0 for 20 cycles, br_taken ignored.
- Reset mid-operation: rst during REQ (ack pending) and during ISSUE → next cycle pc=RST_PC, ir=0, ir_valid=0, halted=0, state REQ.

Source files
------------

// File: rtl/sisc_fetch.sv
// sisc_fetch: instruction fetch unit for the SISC core.
// Owns the program counter, fetches one 32-bit word at a time from
// instruction memory and hands it to the core through the instruction
// register. Branch redirects flush whatever fetch is in flight or waiting
// in ir, and a halt at a delivery parks the unit until reset.
//
// Handshakes:
//   imem_req/imem_ack: imem_req stays high with imem_addr stable from the
//     cycle it rises until the cycle imem_ack=1. That cycle completes the
//     transfer and imem_rdata is sampled. A raised request is never
//     withdrawn except by rst. At most one request is outstanding.
//   ir_valid/ir_ready: a word is delivered in a cycle where both are 1.
//     While ir_valid=1 and ir_ready=0, ir and ir_valid hold their values.
//     The only other way ir_valid drops is a branch flush.
module sisc_fetch #(
    parameter int                ADDR_W = 16,
    parameter logic [ADDR_W-1:0] RST_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       ir,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    input  logic              halt,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        REQ    = 2'd0,
        ISSUE  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] pc_d;
    logic              flush, flush_d;
    logic [ADDR_W-1:0] pending_pc, pending_d;
    logic              ir_load;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= REQ;
        end else begin
            state <= state_d;
        end
    end

    // Next-state, next-pc and flush bookkeeping.
    always_comb begin
        state_d   = state;
        pc_d      = pc;
        flush_d   = flush;
        pending_d = pending_pc;
        ir_load   = 1'b0;
        case (state)
            REQ: begin
                if (imem_ack) begin
                    if (br_taken) begin
                        // Branch lands with the data: drop the word, go to target.
                        pc_d    = br_addr;
                        flush_d = 1'b0;
                    end else if (flush) begin
                        // Data for a request a branch already superseded.
                        pc_d    = pending_pc;
                        flush_d = 1'b0;
                    end else begin
                        ir_load = 1'b1;
                        pc_d    = pc + ADDR_W'(1);
                        state_d = ISSUE;
                    end
                end else if (br_taken) begin
                    // The request cannot be withdrawn; keep imem_addr stable
                    // and remember where to go once its ack arrives.
                    flush_d   = 1'b1;
                    pending_d = br_addr;
                end
            end
            ISSUE: begin
                if (ir_ready) begin
                    // A branch accepted together with its own delivery.
                    if (br_taken) begin
                        pc_d = br_addr;
                    end
                    state_d = halt ? HALTED : REQ;
                end else if (br_taken) begin
                    // Undelivered word is on the wrong path: drop it.
                    pc_d    = br_addr;
                    state_d = REQ;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    // Datapath registers: pc, instruction register and pending redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RST_PC;
            ir         <= '0;
            flush      <= 1'b0;
            pending_pc <= RST_PC;
        end else begin
            pc         <= pc_d;
            flush      <= flush_d;
            pending_pc <= pending_d;
            if (ir_load) begin
                ir <= imem_rdata;
            end
        end
    end

    // Outputs are pure decodes of registered state.
    assign imem_req  = (state == REQ);
    assign imem_addr = pc;
    assign ir_valid  = (state == ISSUE);
    assign halted    = (state == HALTED);
    assign dbg_state = state;

endmodule

// File: tb/tb_sisc_fetch.sv
// tb_sisc_fetch: directed checks of sisc_fetch using a cycle table plus
// hand-written sequences for wait states, flushes, halt, wrap and reset.
module tb_sisc_fetch;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main DUT (RST_PC = 0) ----------------
    logic        imem_req, imem_ack, ir_valid, ir_ready, br_taken, halt, halted;
    logic [15:0] imem_addr, br_addr, pc;
    logic [31:0] imem_rdata, ir;
    logic [1:0]  dbg_state;

    sisc_fetch #(.ADDR_W(16), .RST_PC(16'h0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .br_taken(br_taken), .br_addr(br_addr), .halt(halt),
        .pc(pc), .halted(halted), .dbg_state(dbg_state)
    );

    // Memory model: data = addr*3, ack after wait_cfg wait cycles.
    logic [7:0] wait_cfg = 8'd0;
    logic [7:0] wait_cnt;
    assign imem_ack   = imem_req && (wait_cnt >= wait_cfg);
    assign imem_rdata = {16'h0, imem_addr} * 32'd3;
    always_ff @(posedge clk) begin
        if (rst || !imem_req || imem_ack) wait_cnt <= 8'd0;
        else                              wait_cnt <= wait_cnt + 8'd1;
    end

    // ---------------- wrap DUT (RST_PC = 0xFFFF) ----------------
    logic        imem_req_w, ir_valid_w, halted_w;
    logic [15:0] imem_addr_w, pc_w;
    logic [31:0] ir_w;
    logic [1:0]  dbg_state_w;

    sisc_fetch #(.ADDR_W(16), .RST_PC(16'hFFFF)) dut_w (
        .clk(clk), .rst(rst),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_ack(imem_req_w), .imem_rdata({16'h0, imem_addr_w} * 32'd3),
        .ir(ir_w), .ir_valid(ir_valid_w), .ir_ready(1'b1),
        .br_taken(1'b0), .br_addr(16'h0000), .halt(1'b0),
        .pc(pc_w), .halted(halted_w), .dbg_state(dbg_state_w)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int rdy, input int br, input int baddr, input int hlt);
        ir_ready = (rdy != 0);
        br_taken = (br != 0);
        br_addr  = 16'(baddr);
        halt     = (hlt != 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk({tag, ".state"}, 32'(dbg_state), 32'd0);
        chk({tag, ".pc"}, 32'(pc), 32'h0);
        chk({tag, ".ir"}, ir, 32'h0);
        chk({tag, ".ir_valid"}, 32'(ir_valid), 32'd0);
        chk({tag, ".halted"}, 32'(halted), 32'd0);
        chk({tag, ".imem_req"}, 32'(imem_req), 32'd1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rdy, br, hlt;
        logic [15:0] baddr;
        logic        req, vld;
        logic [31:0] ir;
        logic [15:0] pc;
    } vec_t;
    vec_t vecs[$];

    task automatic addv(input int rdy, input int br, input int baddr, input int hlt,
                        input int req, input int vld, input int irv, input int pcv);
        vec_t v;
        v.rdy = (rdy != 0); v.br = (br != 0); v.baddr = 16'(baddr); v.hlt = (hlt != 0);
        v.req = (req != 0); v.vld = (vld != 0); v.ir = 32'(irv); v.pc = 16'(pcv);
        vecs.push_back(v);
    endtask

    initial begin
        drive(0, 0, 0, 0);

        // Sequential fetch 0,3,6,9,... then branch at handshake, stall, flush.
        //    rdy br baddr hlt | req vld ir    pc
        addv(1, 0, 0,    0,    1,  0,  0,    0);
        addv(1, 0, 0,    0,    0,  1,  0,    1);
        addv(1, 0, 0,    0,    1,  0,  0,    1);
        addv(1, 0, 0,    0,    0,  1,  3,    2);
        addv(1, 0, 0,    0,    1,  0,  3,    2);
        addv(1, 0, 0,    0,    0,  1,  6,    3);
        addv(1, 0, 0,    0,    1,  0,  6,    3);
        addv(1, 0, 0,    0,    0,  1,  9,    4);
        addv(1, 0, 0,    0,    1,  0,  9,    4);
        addv(1, 0, 0,    0,    0,  1,  12,   5);
        addv(1, 0, 0,    0,    1,  0,  12,   5);
        addv(1, 1, 'h40, 0,    0,  1,  15,   6);
        addv(1, 0, 0,    0,    1,  0,  15,   'h40);
        addv(0, 0, 0,    0,    0,  1,  'hC0, 'h41);
        addv(0, 0, 0,    1,    0,  1,  'hC0, 'h41);
        addv(0, 0, 0,    0,    0,  1,  'hC0, 'h41);
        addv(0, 0, 0,    0,    0,  1,  'hC0, 'h41);
        addv(0, 0, 0,    0,    0,  1,  'hC0, 'h41);
        addv(1, 0, 0,    0,    0,  1,  'hC0, 'h41);
        addv(1, 0, 0,    0,    1,  0,  'hC0, 'h41);
        addv(0, 1, 7,    0,    0,  1,  'hC3, 'h42);
        addv(1, 0, 0,    0,    1,  0,  'hC3, 7);

        // ---- wrap: RST_PC = 0xFFFF wraps to 0 after first delivery ----
        do_reset("rst0");
        chk("wrap.pc0", 32'(pc_w), 32'hFFFF);
        chk("wrap.req0", 32'(imem_req_w), 32'd1);
        tick();
        chk("wrap.vld", 32'(ir_valid_w), 32'd1);
        chk("wrap.ir", ir_w, 32'h0002FFFD);
        chk("wrap.pc1", 32'(pc_w), 32'h0);
        tick();
        chk("wrap.addr", 32'(imem_addr_w), 32'h0);

        // ---- table-driven run ----
        wait_cfg = 8'd0;
        do_reset("rst1");
        for (int i = 0; i < vecs.size(); i++) begin
            drive(int'(vecs[i].rdy), int'(vecs[i].br), int'(vecs[i].baddr), int'(vecs[i].hlt));
            chk($sformatf("v%0d.req", i), 32'(imem_req), 32'(vecs[i].req));
            chk($sformatf("v%0d.addr", i), 32'(imem_addr), 32'(vecs[i].pc));
            chk($sformatf("v%0d.vld", i), 32'(ir_valid), 32'(vecs[i].vld));
            chk($sformatf("v%0d.ir", i), ir, vecs[i].ir);
            chk($sformatf("v%0d.pc", i), 32'(pc), 32'(vecs[i].pc));
            chk($sformatf("v%0d.halted", i), 32'(halted), 32'd0);
            tick();
        end

        // ---- wait states: 3 waits -> request held 4 cycles, N+2 latency ----
        wait_cfg = 8'd3;
        do_reset("rst2");
        drive(1, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ws0.req%0d", k), 32'(imem_req), 32'd1);
            chk($sformatf("ws0.addr%0d", k), 32'(imem_addr), 32'h0);
            chk($sformatf("ws0.vld%0d", k), 32'(ir_valid), 32'd0);
            tick();
        end
        chk("ws0.deliver", 32'(ir_valid), 32'd1);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ws1.req%0d", k), 32'(imem_req), 32'd1);
            chk($sformatf("ws1.addr%0d", k), 32'(imem_addr), 32'h1);
            chk($sformatf("ws1.vld%0d", k), 32'(ir_valid), 32'd0);
            tick();
        end
        chk("ws1.vld", 32'(ir_valid), 32'd1);
        chk("ws1.ir", ir, 32'h3);

        // ---- branch during an outstanding request to address 7 ----
        wait_cfg = 8'd0;
        do_reset("rst3");
        drive(0, 0, 0, 0);
        tick();                                   // ISSUE, word 0 waiting
        chk("bo.issue", 32'(ir_valid), 32'd1);
        drive(0, 1, 7, 0);
        wait_cfg = 8'd3;
        tick();                                   // REQ at 7
        drive(0, 1, 'h20, 0);
        chk("bo.addr7", 32'(imem_addr), 32'h7);
        tick();
        drive(0, 0, 0, 0);
        for (int k = 1; k < 4; k++) begin
            chk($sformatf("bo.hold%0d", k), 32'(imem_addr), 32'h7);
            chk($sformatf("bo.req%0d", k), 32'(imem_req), 32'd1);
            chk($sformatf("bo.vld%0d", k), 32'(ir_valid), 32'd0);
            tick();
        end
        chk("bo.discard_vld", 32'(ir_valid), 32'd0);
        chk("bo.new_addr", 32'(imem_addr), 32'h20);
        wait_cfg = 8'd0;
        drive(1, 0, 0, 0);
        tick();
        chk("bo.ir", ir, 32'h60);
        chk("bo.pc", 32'(pc), 32'h21);
        tick();                                   // REQ at 0x21, ack same cycle
        drive(1, 1, 'h30, 0);
        chk("bsame.addr", 32'(imem_addr), 32'h21);
        tick();
        drive(1, 0, 0, 0);
        chk("bsame.vld", 32'(ir_valid), 32'd0);
        chk("bsame.new_addr", 32'(imem_addr), 32'h30);
        chk("bsame.ir_kept", ir, 32'h60);
        tick();
        chk("bsame.ir", ir, 32'h90);

        // ---- halt: ignored without ir_ready, then halt+branch at handshake ----
        drive(0, 0, 0, 1);
        tick();
        chk("h.ignored_vld", 32'(ir_valid), 32'd1);
        chk("h.ignored_halted", 32'(halted), 32'd0);
        drive(1, 1, 'h55, 1);
        tick();
        chk("h.halted", 32'(halted), 32'd1);
        chk("h.pc", 32'(pc), 32'h55);
        for (int k = 0; k < 20; k++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 65535),
                  $urandom_range(0, 1));
            tick();
            chk($sformatf("h.req%0d", k), 32'(imem_req), 32'd0);
            chk($sformatf("h.st%0d", k), {31'd0, halted} | {30'd0, ir_valid, 1'b0}, 32'd1);
            chk($sformatf("h.pc%0d", k), 32'(pc), 32'h55);
        end

        // ---- reset mid-operation: REQ with ack pending, then ISSUE ----
        wait_cfg = 8'd3;
        do_reset("rst_halted");
        drive(0, 0, 0, 0);
        tick();
        do_reset("rst_req");
        wait_cfg = 8'd0;
        drive(1, 0, 0, 0);
        tick();
        drive(1, 1, 5, 0);
        tick();
        drive(0, 0, 0, 0);
        tick();
        chk("ri.ir", ir, 32'hF);
        chk("ri.vld", 32'(ir_valid), 32'd1);
        do_reset("rst_issue");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
